// File: rtl/sdr_app_arbiter.sv
// -----------------------------------------------------------------------------
// sdr_app_arbiter
//
// Two-client burst arbiter in front of an SDRAM controller application port.
// A writer and a reader each request whole bursts of BURST_LEN words. The
// arbiter grants one burst at a time, alternating between the two when both
// are pending, and sequences the per-word commands to the controller.
//
// Ports
//   Clk, Rst                  sole clock; synchronous active-high reset
//   Sdr_init_done, Sdr_busy   controller status
//   Wr_req/Wr_addr/Wr_gnt     writer burst handshake (address latched at grant)
//   Wr_data_req/Wr_din/Wr_dm  first-word-fall-through write data pull
//   Wr_done                   pulse with the last App_wr_en of a burst
//   Rd_req/Rd_addr/Rd_gnt     reader burst handshake (address latched at grant)
//   Rd_valid/Rd_dout/Rd_done  returned read data, done with the last word
//   App_wr_*                  registered write command to the controller
//   App_rd_en/App_rd_addr     registered read command to the controller
//   Sdr_rd_en/Sdr_rd_dout     read data returned by the controller
// -----------------------------------------------------------------------------
module sdr_app_arbiter #(
   parameter int unsigned ADDR_WIDTH = 21,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DM_WIDTH   = 4,
   parameter int unsigned BURST_LEN  = 8
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Sdr_init_done,
   input  logic                  Sdr_busy,
   input  logic                  Wr_req,
   input  logic [ADDR_WIDTH-1:0] Wr_addr,
   output logic                  Wr_gnt,
   output logic                  Wr_data_req,
   input  logic [DATA_WIDTH-1:0] Wr_din,
   input  logic [DM_WIDTH-1:0]   Wr_dm,
   output logic                  Wr_done,
   input  logic                  Rd_req,
   input  logic [ADDR_WIDTH-1:0] Rd_addr,
   output logic                  Rd_gnt,
   output logic                  Rd_valid,
   output logic [DATA_WIDTH-1:0] Rd_dout,
   output logic                  Rd_done,
   output logic                  App_wr_en,
   output logic [ADDR_WIDTH-1:0] App_wr_addr,
   output logic [DATA_WIDTH-1:0] App_wr_din,
   output logic [DM_WIDTH-1:0]   App_wr_dm,
   output logic                  App_rd_en,
   output logic [ADDR_WIDTH-1:0] App_rd_addr,
   input  logic                  Sdr_rd_en,
   input  logic [DATA_WIDTH-1:0] Sdr_rd_dout
);

   // One extra bit so the counters can hold BURST_LEN itself (burst complete).
   localparam int unsigned CNT_WIDTH = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);
   localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      StIdle,
      StWrBurst,
      StRdIssue,
      StRdWait
   } state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] start_addr_q;
   logic [CNT_WIDTH-1:0]  word_cnt_q;     // words pulled (write) or issued (read)
   logic [CNT_WIDTH-1:0]  ret_cnt_q;      // read words returned
   logic                  last_gnt_wr_q;  // 1: last grant went to the writer

   logic                  wr_gnt_q;
   logic                  rd_gnt_q;
   logic                  wr_done_q;
   logic                  rd_done_q;
   logic                  app_wr_en_q;
   logic [ADDR_WIDTH-1:0] app_wr_addr_q;
   logic [DATA_WIDTH-1:0] app_wr_din_q;
   logic [DM_WIDTH-1:0]   app_wr_dm_q;
   logic                  app_rd_en_q;
   logic [ADDR_WIDTH-1:0] app_rd_addr_q;
   logic                  rd_valid_q;
   logic [DATA_WIDTH-1:0] rd_dout_q;

   logic                  wr_pull;
   logic                  rd_issue;
   logic                  rd_accept;
   logic [ADDR_WIDTH-1:0] word_addr;

   always_comb begin
      // Truncation to ADDR_WIDTH gives the wrap past the top address.
      word_addr = start_addr_q + ADDR_WIDTH'(word_cnt_q);
      wr_pull   = (state_q == StWrBurst) && (word_cnt_q < BURST_CNT) && !Sdr_busy;
      rd_issue  = (state_q == StRdIssue) && (word_cnt_q < BURST_CNT) && !Sdr_busy;
      // Returns are only ours while a read burst is open and not yet complete;
      // anything else is stray data (e.g. left over from before a reset).
      rd_accept = ((state_q == StRdIssue) || (state_q == StRdWait)) && Sdr_rd_en &&
                  (ret_cnt_q < BURST_CNT);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q       <= StIdle;
         start_addr_q  <= '0;
         word_cnt_q    <= '0;
         ret_cnt_q     <= '0;
         last_gnt_wr_q <= 1'b0;
         wr_gnt_q      <= 1'b0;
         rd_gnt_q      <= 1'b0;
         wr_done_q     <= 1'b0;
         rd_done_q     <= 1'b0;
         app_wr_en_q   <= 1'b0;
         app_wr_addr_q <= '0;
         app_wr_din_q  <= '0;
         app_wr_dm_q   <= '0;
         app_rd_en_q   <= 1'b0;
         app_rd_addr_q <= '0;
         rd_valid_q    <= 1'b0;
         rd_dout_q     <= '0;
      end else begin
         // Strobes default low; data/address registers hold their last value.
         wr_gnt_q    <= 1'b0;
         rd_gnt_q    <= 1'b0;
         wr_done_q   <= 1'b0;
         rd_done_q   <= 1'b0;
         app_wr_en_q <= 1'b0;
         app_rd_en_q <= 1'b0;
         rd_valid_q  <= 1'b0;

         case (state_q)
            StIdle: begin
               // The grant pulse cycle is spent in idle; leave on the next edge
               // rather than arbitrating again.
               if (wr_gnt_q) begin
                  state_q <= StWrBurst;
               end else if (rd_gnt_q) begin
                  state_q <= StRdIssue;
               end else if (Sdr_init_done && (Wr_req || Rd_req)) begin
                  word_cnt_q <= '0;
                  ret_cnt_q  <= '0;
                  if (Wr_req && (!Rd_req || !last_gnt_wr_q)) begin
                     wr_gnt_q      <= 1'b1;
                     last_gnt_wr_q <= 1'b1;
                     start_addr_q  <= Wr_addr;
                  end else begin
                     rd_gnt_q      <= 1'b1;
                     last_gnt_wr_q <= 1'b0;
                     start_addr_q  <= Rd_addr;
                  end
               end
            end

            StWrBurst: begin
               if (wr_pull) begin
                  app_wr_en_q   <= 1'b1;
                  app_wr_addr_q <= word_addr;
                  app_wr_din_q  <= Wr_din;
                  app_wr_dm_q   <= Wr_dm;
                  word_cnt_q    <= word_cnt_q + 1'b1;
                  wr_done_q     <= (word_cnt_q == LAST_CNT);
               end
               // Done is visible for one cycle, then back to idle.
               if (wr_done_q) begin
                  state_q <= StIdle;
               end
            end

            StRdIssue: begin
               if (rd_issue) begin
                  app_rd_en_q   <= 1'b1;
                  app_rd_addr_q <= word_addr;
                  word_cnt_q    <= word_cnt_q + 1'b1;
                  if (word_cnt_q == LAST_CNT) begin
                     state_q <= StRdWait;
                  end
               end
            end

            StRdWait: begin
               // Only the return path below is active here.
            end

            default: begin
               state_q <= StIdle;
            end
         endcase

         if (rd_accept) begin
            rd_valid_q <= 1'b1;
            rd_dout_q  <= Sdr_rd_dout;
            ret_cnt_q  <= ret_cnt_q + 1'b1;
            rd_done_q  <= (ret_cnt_q == LAST_CNT);
         end
         if (rd_done_q) begin
            state_q <= StIdle;
         end
      end
   end

   assign Wr_gnt      = wr_gnt_q;
   assign Wr_data_req = wr_pull;
   assign Wr_done     = wr_done_q;
   assign Rd_gnt      = rd_gnt_q;
   assign Rd_valid    = rd_valid_q;
   assign Rd_dout     = rd_dout_q;
   assign Rd_done     = rd_done_q;
   assign App_wr_en   = app_wr_en_q;
   assign App_wr_addr = app_wr_addr_q;
   assign App_wr_din  = app_wr_din_q;
   assign App_wr_dm   = app_wr_dm_q;
   assign App_rd_en   = app_rd_en_q;
   assign App_rd_addr = app_rd_addr_q;

endmodule

// File: tb/tb_sdr_app_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdr_app_arbiter
//
// Random and directed stimulus for sdr_app_arbiter, checked every cycle against
// a transaction-level model: grants follow the alternation rule, each granted
// burst produces BURST_LEN words at start+index (mod 2^ADDR_WIDTH), and read
// returns are forwarded one cycle later only while a read burst is open.
// -----------------------------------------------------------------------------
module tb_sdr_app_arbiter;

   localparam int unsigned AW = 21;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 4;
   localparam int unsigned BL = 8;

   // Model phases (what the arbiter is doing from the outside point of view).
   localparam int MIdle  = 0;
   localparam int MWrGnt = 1;
   localparam int MRdGnt = 2;
   localparam int MWr    = 3;
   localparam int MWrEnd = 4;
   localparam int MRd    = 5;
   localparam int MRdEnd = 6;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          Sdr_init_done;
   logic          Sdr_busy;
   logic          Wr_req;
   logic [AW-1:0] Wr_addr;
   logic          Wr_gnt;
   logic          Wr_data_req;
   logic [DW-1:0] Wr_din;
   logic [MW-1:0] Wr_dm;
   logic          Wr_done;
   logic          Rd_req;
   logic [AW-1:0] Rd_addr;
   logic          Rd_gnt;
   logic          Rd_valid;
   logic [DW-1:0] Rd_dout;
   logic          Rd_done;
   logic          App_wr_en;
   logic [AW-1:0] App_wr_addr;
   logic [DW-1:0] App_wr_din;
   logic [MW-1:0] App_wr_dm;
   logic          App_rd_en;
   logic [AW-1:0] App_rd_addr;
   logic          Sdr_rd_en;
   logic [DW-1:0] Sdr_rd_dout;

   always #5 Clk = ~Clk;

   sdr_app_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DM_WIDTH   (MW),
      .BURST_LEN  (BL)
   ) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Sdr_init_done (Sdr_init_done),
      .Sdr_busy      (Sdr_busy),
      .Wr_req        (Wr_req),
      .Wr_addr       (Wr_addr),
      .Wr_gnt        (Wr_gnt),
      .Wr_data_req   (Wr_data_req),
      .Wr_din        (Wr_din),
      .Wr_dm         (Wr_dm),
      .Wr_done       (Wr_done),
      .Rd_req        (Rd_req),
      .Rd_addr       (Rd_addr),
      .Rd_gnt        (Rd_gnt),
      .Rd_valid      (Rd_valid),
      .Rd_dout       (Rd_dout),
      .Rd_done       (Rd_done),
      .App_wr_en     (App_wr_en),
      .App_wr_addr   (App_wr_addr),
      .App_wr_din    (App_wr_din),
      .App_wr_dm     (App_wr_dm),
      .App_rd_en     (App_rd_en),
      .App_rd_addr   (App_rd_addr),
      .Sdr_rd_en     (Sdr_rd_en),
      .Sdr_rd_dout   (Sdr_rd_dout)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc      = 0;

   // Stimulus knobs
   int unsigned   p_busy, p_wr, p_rd, p_stray;
   bit            k_init, rst_next, rand_addr;
   int            busy_hold;
   logic [AW-1:0] wr_addr_v, rd_addr_v;

   // Reference model
   int            m_mode, m_cnt, m_ret;
   bit            m_last_wr;
   logic [AW-1:0] m_start;
   bit            e_wgnt, e_rgnt, e_wen, e_ren, e_rvalid, e_wdone, e_rdone, e_zero;
   logic [AW-1:0] e_waddr, e_raddr;
   logic [DW-1:0] e_wdin, e_rdout;
   logic [MW-1:0] e_wdm;

   // Controller read-return model: due cycle and data per issued read.
   int unsigned   rq_due[$];
   logic [DW-1:0] rq_data[$];

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic schedule_return();
      int unsigned due;
      due = cyc + 2 + $urandom_range(3);
      if (rq_due.size() > 0 && due <= rq_due[rq_due.size()-1]) begin
         due = rq_due[rq_due.size()-1] + 1;
      end
      rq_due.push_back(due);
      rq_data.push_back($urandom);
   endtask

   // One clock cycle: check registered outputs, drive inputs, check
   // Wr_data_req, then advance the model across the coming edge.
   task automatic step();
      bit exp_dreq;
      @(posedge Clk);
      #1;
      cyc++;
      check_eq("ctl", 128'({Wr_gnt, Rd_gnt, App_wr_en, App_rd_en, Rd_valid, Wr_done, Rd_done}),
               128'({e_wgnt, e_rgnt, e_wen, e_ren, e_rvalid, e_wdone, e_rdone}));
      if (e_wen) begin
         check_eq("wr_addr", 128'(App_wr_addr), 128'(e_waddr));
         check_eq("wr_din", 128'(App_wr_din), 128'(e_wdin));
         check_eq("wr_dm", 128'(App_wr_dm), 128'(e_wdm));
      end
      if (e_ren) check_eq("rd_addr", 128'(App_rd_addr), 128'(e_raddr));
      if (e_rvalid) check_eq("rd_dout", 128'(Rd_dout), 128'(e_rdout));
      if (e_zero) begin
         check_eq("rst_zero", 128'({App_wr_addr, App_wr_din, App_wr_dm, App_rd_addr, Rd_dout,
                                    Wr_data_req}), 128'(0));
      end

      // Drive this cycle's inputs.
      Rst           = rst_next;
      rst_next      = 1'b0;
      Sdr_init_done = k_init;
      Wr_req        = ($urandom_range(99) < p_wr);
      Rd_req        = ($urandom_range(99) < p_rd);
      Wr_addr       = wr_addr_v;
      Rd_addr       = rd_addr_v;
      Wr_din        = $urandom;
      Wr_dm         = 4'($urandom);
      if (busy_hold > 0) begin
         Sdr_busy = 1'b1;
         busy_hold--;
      end else begin
         Sdr_busy = ($urandom_range(99) < p_busy);
      end
      Sdr_rd_en   = 1'b0;
      Sdr_rd_dout = $urandom;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
         Sdr_rd_en   = 1'b1;
         Sdr_rd_dout = rq_data.pop_front();
         void'(rq_due.pop_front());
      end else if (rq_due.size() == 0 && m_mode != MRd && m_mode != MRdGnt &&
                   m_mode != MRdEnd && $urandom_range(99) < p_stray) begin
         Sdr_rd_en = 1'b1;
      end

      #1;
      exp_dreq = (m_mode == MWr) && (m_cnt < BL) && !Sdr_busy;
      check_eq("data_req", 128'(Wr_data_req), 128'(exp_dreq));

      // Model the effect of the coming clock edge.
      {e_wgnt, e_rgnt, e_wen, e_ren, e_rvalid, e_wdone, e_rdone, e_zero} = '0;
      if (Rst) begin
         m_mode    = MIdle;
         m_last_wr = 1'b0;
         e_zero    = 1'b1;
      end else begin
         case (m_mode)
            MIdle: begin
               if (Sdr_init_done && (Wr_req || Rd_req)) begin
                  if (Wr_req && (!Rd_req || !m_last_wr)) begin
                     e_wgnt    = 1'b1;
                     m_start   = Wr_addr;
                     m_last_wr = 1'b1;
                     m_mode    = MWrGnt;
                  end else begin
                     e_rgnt    = 1'b1;
                     m_start   = Rd_addr;
                     m_last_wr = 1'b0;
                     m_mode    = MRdGnt;
                  end
               end
            end
            MWrGnt, MRdGnt: begin
               m_mode = (m_mode == MWrGnt) ? MWr : MRd;
               m_cnt  = 0;
               m_ret  = 0;
               if (rand_addr) begin
                  wr_addr_v = 21'($urandom);
                  rd_addr_v = 21'($urandom);
               end
            end
            MWr: begin
               if (exp_dreq) begin
                  e_wen   = 1'b1;
                  e_waddr = AW'(m_start + AW'(m_cnt));
                  e_wdin  = Wr_din;
                  e_wdm   = Wr_dm;
                  m_cnt++;
                  if (m_cnt == BL) begin
                     e_wdone = 1'b1;
                     m_mode  = MWrEnd;
                  end
               end
            end
            MRd: begin
               if (m_cnt < BL && !Sdr_busy) begin
                  e_ren   = 1'b1;
                  e_raddr = AW'(m_start + AW'(m_cnt));
                  m_cnt++;
                  schedule_return();
               end
               if (Sdr_rd_en && m_ret < BL) begin
                  e_rvalid = 1'b1;
                  e_rdout  = Sdr_rd_dout;
                  m_ret++;
                  if (m_ret == BL) begin
                     e_rdone = 1'b1;
                     m_mode  = MRdEnd;
                  end
               end
            end
            default: m_mode = MIdle;  // MWrEnd, MRdEnd
         endcase
      end
   endtask

   // Step until the model reaches a phase (and word count, if cnt >= 0).
   task automatic run_until(input int mode, input int cnt, input int bound, input string tag);
      bit reached;
      reached = (m_mode == mode) && (cnt < 0 || m_cnt == cnt);
      for (int i = 0; i < bound && !reached; i++) begin
         step();
         reached = (m_mode == mode) && (cnt < 0 || m_cnt == cnt);
      end
      check_eq({tag, "_reached"}, 128'(reached), 128'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b1; Sdr_init_done = 1'b0; Sdr_busy = 1'b0; Wr_req = 1'b0; Rd_req = 1'b0;
      Wr_addr = '0; Rd_addr = '0; Wr_din = '0; Wr_dm = '0; Sdr_rd_en = 1'b0; Sdr_rd_dout = '0;
      p_busy = 0; p_wr = 0; p_rd = 0; p_stray = 0; k_init = 1'b0; rst_next = 1'b1;
      rand_addr = 1'b0; busy_hold = 0; wr_addr_v = '0; rd_addr_v = '0;
      m_mode = MIdle; m_cnt = 0; m_ret = 0; m_last_wr = 1'b0; m_start = '0;
      {e_wgnt, e_rgnt, e_wen, e_ren, e_rvalid, e_wdone, e_rdone} = '0;
      e_zero = 1'b1;
      e_waddr = '0; e_raddr = '0; e_wdin = '0; e_rdout = '0; e_wdm = '0;
      repeat (2) @(posedge Clk);

      // Reset state, then init gating with both requests pending, then ties.
      step();
      p_wr = 100; p_rd = 100;
      repeat (6) step();
      k_init = 1'b1;
      repeat (60) step();
      p_wr = 0; p_rd = 0;
      run_until(MIdle, -1, 100, "tie_idle");

      // Single write at 0x100, no busy.
      wr_addr_v = 21'h100; p_wr = 100;
      run_until(MWrGnt, -1, 10, "w100_gnt");
      p_wr = 0;
      run_until(MIdle, -1, 40, "w100_idle");

      // Write with a 3-cycle busy stall after 4 words.
      wr_addr_v = 21'h0ABC0; p_wr = 100;
      run_until(MWrGnt, -1, 10, "stall_gnt");
      p_wr = 0;
      run_until(MWr, 4, 20, "stall_mid");
      busy_hold = 3;
      run_until(MIdle, -1, 40, "stall_idle");

      // Read crossing the top of the address space, gapped returns.
      rd_addr_v = 21'h1FFFFC; p_rd = 100;
      run_until(MRdGnt, -1, 10, "wrap_gnt");
      p_rd = 0;
      run_until(MIdle, -1, 80, "wrap_idle");

      // Reset after 4 write words, then a normal write.
      wr_addr_v = 21'h00200; p_wr = 100;
      run_until(MWrGnt, -1, 10, "rstw_gnt");
      p_wr = 0;
      run_until(MWr, 4, 20, "rstw_mid");
      rst_next = 1'b1;
      step();
      step();
      wr_addr_v = 21'h00300; p_wr = 100;
      run_until(MWrGnt, -1, 10, "rstw_regnt");
      p_wr = 0;
      run_until(MIdle, -1, 40, "rstw_idle");

      // Reset with read data still in flight: late returns must be dropped.
      rd_addr_v = 21'h01000; p_rd = 100;
      run_until(MRdGnt, -1, 10, "rstr_gnt");
      p_rd = 0;
      run_until(MRd, BL, 20, "rstr_issued");
      rst_next = 1'b1;
      repeat (20) step();

      // Randomized traffic with busy, strays and occasional reset.
      p_busy = 25; p_wr = 40; p_rd = 40; p_stray = 10; rand_addr = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(299) == 0) rst_next = 1'b1;
         step();
      end
      p_wr = 0; p_rd = 0;
      run_until(MIdle, -1, 100, "final_idle");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
